// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg -- shared definitions for the PWM bank.
//
// Holds the register map base addresses, the ctrl register bit positions,
// the register-type enum and the address decoder used by pwm_bank.
package pwm_bank_pkg;

  // Register map: duty shadows at 0x00+i, ctrl at 0x40+i, one prescaler at 0x80.
  localparam logic [7:0] ADDR_DUTY_BASE = 8'h00;
  localparam logic [7:0] ADDR_CTRL_BASE = 8'h40;
  localparam logic [7:0] ADDR_PRESC     = 8'h80;

  // Per-channel ctrl register layout.
  localparam int CTRL_W      = 2;
  localparam int CTRL_EN_OUT = 0;
  localparam int CTRL_EN_PWM = 1;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DUTY,
    REG_CTRL,
    REG_PRESC
  } reg_type_e;

  // Classify an address; addresses of channels that do not exist decode as REG_NONE.
  function automatic reg_type_e decode_reg(input logic [7:0] addr, input int num_ch);
    int a;
    a = int'(addr);
    if (addr == ADDR_PRESC) return REG_PRESC;
    if (a >= int'(ADDR_DUTY_BASE) && a < int'(ADDR_DUTY_BASE) + num_ch) return REG_DUTY;
    if (a >= int'(ADDR_CTRL_BASE) && a < int'(ADDR_CTRL_BASE) + num_ch) return REG_CTRL;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// pwm_bank_channel -- one PWM channel: duty register(s), ctrl register and
// the registered compare output.
//
// Build option: PWM_BANK_SYNC_UPDATE_EN adds an active duty register that is
// loaded from the shadow at each period wrap; without it the compare uses the
// shadow duty directly.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   duty_we     write wr_data into this channel's duty shadow
//   ctrl_we     write wr_data[1:0] into this channel's ctrl register
//   wr_data     write data
//   cnt         shared period counter
//   wrap_tick   tick on which the period counter wraps to 0
//   out         registered PWM output
module pwm_bank_channel
  import pwm_bank_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             duty_we,
  input  logic             ctrl_we,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [CNT_W-1:0] cnt,
  input  logic             wrap_tick,
  output logic             out
);

  logic [CNT_W-1:0]  shadow;
  logic [CTRL_W-1:0] ctrl;
  logic [CNT_W-1:0]  duty_cmp;
  logic              out_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      ctrl   <= '0;
    end else begin
      if (duty_we) shadow <= wr_data;
      if (ctrl_we) ctrl   <= wr_data[CTRL_W-1:0];
    end
  end

`ifdef PWM_BANK_SYNC_UPDATE_EN
  logic [CNT_W-1:0] active;

  // A duty write landing on the wrap tick must win over the stale shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
    end else if (wrap_tick) begin
      active <= duty_we ? wr_data : shadow;
    end
  end

  assign duty_cmp = active;
`else
  logic unused_wrap_tick;
  assign unused_wrap_tick = wrap_tick;
  assign duty_cmp         = shadow;
`endif

  // All-ones duty must stay high through the whole period, including the
  // counter value 2^CNT_W-2 where cnt < duty alone would still hold but the
  // explicit term keeps the intent obvious.
  always_comb begin
    out_next = 1'b0;
    if (!ctrl[CTRL_EN_OUT]) begin
      out_next = 1'b0;
    end else if (!ctrl[CTRL_EN_PWM]) begin
      out_next = 1'b1;
    end else begin
      out_next = (cnt < duty_cmp) || (&duty_cmp);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= 1'b0;
    else        out <= out_next;
  end

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank -- bank of NUM_CH PWM channels sharing a prescaler and a period
// counter that runs 0..2^CNT_W-2 (period of 2^CNT_W-1 ticks).
//
// Build option: PWM_BANK_SYNC_UPDATE_EN (see pwm_bank_channel) selects
// wrap-synchronous duty updates; default is immediate duty updates.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   wr_en         register write strobe
//   wr_addr       register address (0x00+i duty, 0x40+i ctrl, 0x80 prescaler)
//   wr_data       write data, upper bits ignored for narrower registers
//   out           registered PWM outputs, bit i = channel i
//   period_pulse  one-cycle pulse after each period wrap tick
//
// Handshake: there is none; a write is accepted in every cycle wr_en is high.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_pulse
);

  localparam int WR_W = (PRESC_W > CNT_W) ? PRESC_W : CNT_W;
  // Last counter value before the wrap: 2^CNT_W-2.
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

  reg_type_e        wr_type;
  logic [5:0]       wr_idx;
  logic             presc_we;
  logic [WR_W-1:0]  wr_ext;
  logic [PRESC_W-1:0] presc_reg;
  logic [PRESC_W-1:0] presc_cnt;
  logic             tick;
  logic [CNT_W-1:0] cnt;
  logic             wrap_tick;

  assign wr_type  = decode_reg(wr_addr, NUM_CH);
  assign wr_idx   = wr_addr[5:0];
  assign presc_we = wr_en && (wr_type == REG_PRESC);
  assign wr_ext   = WR_W'(wr_data);

  logic unused_wr_ext;
  assign unused_wr_ext = ^wr_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        presc_reg <= '0;
    else if (presc_we) presc_reg <= wr_ext[PRESC_W-1:0];
  end

  assign tick = (presc_cnt == presc_reg);

  // A prescaler write restarts the tick spacing from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        presc_cnt <= '0;
    else if (presc_we) presc_cnt <= '0;
    else if (tick)     presc_cnt <= '0;
    else               presc_cnt <= presc_cnt + 1'b1;
  end

  assign wrap_tick = tick && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_pulse <= 1'b0;
    end else begin
      period_pulse <= wrap_tick;
      if (wrap_tick) cnt <= '0;
      else if (tick) cnt <= cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic duty_we;
    logic ctrl_we;
    assign duty_we = wr_en && (wr_type == REG_DUTY) && (wr_idx == 6'(i));
    assign ctrl_we = wr_en && (wr_type == REG_CTRL) && (wr_idx == 6'(i));

    pwm_bank_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .duty_we   (duty_we),
      .ctrl_we   (ctrl_we),
      .wr_data   (wr_data),
      .cnt       (cnt),
      .wrap_tick (wrap_tick),
      .out       (out[i])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank -- self-checking bench for pwm_bank (NUM_CH=16, CNT_W=8, PRESC_W=8).
module tb_pwm_bank;

  localparam int NCH    = 16;
  localparam int CW     = 8;
  localparam int PW     = 8;
  localparam int PERIOD = (1 << CW) - 1;
  localparam int ONES   = (1 << CW) - 1;

  logic           clk;
  logic           rst_n;
  logic           wr_en;
  logic [7:0]     wr_addr;
  logic [CW-1:0]  wr_data;
  logic [NCH-1:0] out;
  logic           period_pulse;

  int checks = 0;
  int errors = 0;

  pwm_bank #(
    .NUM_CH  (NCH),
    .CNT_W   (CW),
    .PRESC_W (PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .out          (out),
    .period_pulse (period_pulse)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Tracks tick count within the prescale interval and the position in the
  // period as plain integers; the output of each channel is derived from the
  // written duty/ctrl values with ordinary arithmetic.
  int m_presc = 0;
  int m_pcnt  = 0;
  int m_pos   = 0;
  int m_shadow [NCH];
  int m_active [NCH];
  int m_ctrl   [NCH];
  logic [NCH-1:0] m_out = '0;
  logic           m_pulse = 1'b0;

  function automatic logic level(input int ctrl, input int duty, input int pos);
    if ((ctrl & 1) == 0) return 1'b0;
    if ((ctrl & 2) == 0) return 1'b1;
    return (pos < duty) || (duty == ONES);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_presc = 0; m_pcnt = 0; m_pos = 0; m_out = '0; m_pulse = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_shadow[i] = 0; m_active[i] = 0; m_ctrl[i] = 0;
      end
    end else begin
      int a;
      logic tick;
      logic wrap;
      a    = int'(wr_addr);
      tick = (m_pcnt == m_presc);
      wrap = tick && (m_pos == PERIOD - 1);
      for (int i = 0; i < NCH; i++) begin
`ifdef PWM_BANK_SYNC_UPDATE_EN
        m_out[i] = level(m_ctrl[i], m_active[i], m_pos);
`else
        m_out[i] = level(m_ctrl[i], m_shadow[i], m_pos);
`endif
      end
      m_pulse = wrap;
`ifdef PWM_BANK_SYNC_UPDATE_EN
      if (wrap) begin
        for (int i = 0; i < NCH; i++)
          m_active[i] = (wr_en && a == i) ? int'(wr_data) : m_shadow[i];
      end
`endif
      if (wr_en && a < NCH) m_shadow[a] = int'(wr_data);
      if (wr_en && a >= 64 && a < 64 + NCH) m_ctrl[a-64] = int'(wr_data) & 3;
      if (tick) m_pos = (m_pos + 1) % PERIOD;
      if (wr_en && a == 128) begin
        m_presc = int'(wr_data);
        m_pcnt  = 0;
      end else if (tick) begin
        m_pcnt = 0;
      end else begin
        m_pcnt = m_pcnt + 1;
      end
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk) begin
    checks++;
    if (out !== m_out) begin
      errors++;
      if (errors < 20) $display("FAIL out t=%0t actual %h expected %h", $time, out, m_out);
    end
    checks++;
    if (period_pulse !== m_pulse) begin
      errors++;
      if (errors < 20) $display("FAIL period_pulse t=%0t actual %0b expected %0b", $time, period_pulse, m_pulse);
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Returns at a negedge where period_pulse is high (checks the current one first).
  task automatic wait_pulse();
    int n;
    n = 0;
    while (period_pulse !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (period_pulse !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_pulse actual timeout expected pulse within 3000 cycles");
    end
  endtask

  // Counts high cycles of out[ch] over the n cycles following a period pulse,
  // optionally writing (wa, wd) at iteration wr_at; also checks the next pulse
  // arrives exactly n cycles later.
  task automatic measure(input string name, input int ch, input int n, input int wr_at,
                         input logic [7:0] wa, input logic [7:0] wd, output int highs);
    int first_pulse;
    wait_pulse();
    highs = 0;
    first_pulse = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (out[ch]) highs++;
      if (period_pulse && first_pulse < 0) first_pulse = k;
      if (k == wr_at) begin
        wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      end else begin
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0;
    chk({name, "_period_len"}, first_pulse + 1, n);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int h;
    int nz;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", int'(out), 0);
    chk("reset_pulse", int'(period_pulse), 0);
    rst_n = 1'b1;

    // ch0 duty 0x80 enabled, prescaler 0: 128 of 255 cycles high
    wr(8'h00, 8'h80);
    wr(8'h40, 8'h03);
    measure("ch0_duty80", 0, PERIOD, -1, 8'h0, 8'h0, h);
    chk("ch0_duty80_highs", h, 128);
    measure("ch0_duty80_b", 0, PERIOD, -1, 8'h0, 8'h0, h);
    chk("ch0_duty80_highs_b", h, 128);

    // ch3 duty 0 then all ones
    wr(8'h03, 8'h00);
    wr(8'h43, 8'h03);
    measure("ch3_duty00", 3, PERIOD, -1, 8'h0, 8'h0, h);
    chk("ch3_duty00_highs", h, 0);
    wr(8'h03, 8'hFF);
    measure("ch3_dutyFF", 3, PERIOD, -1, 8'h0, 8'h0, h);
    chk("ch3_dutyFF_highs", h, PERIOD);

    // ch2 duty 0x40 -> 0xC0 written 100 cycles into a period
    wr(8'h02, 8'h40);
    wr(8'h42, 8'h03);
    measure("ch2_duty40", 2, PERIOD, -1, 8'h0, 8'h0, h);
    chk("ch2_duty40_highs", h, 64);
    measure("ch2_midwrite", 2, PERIOD, 100, 8'h02, 8'hC0, h);
`ifdef PWM_BANK_SYNC_UPDATE_EN
    chk("ch2_midwrite_highs", h, 64);
`else
    chk("ch2_midwrite_highs", h, 154);
`endif
    measure("ch2_dutyC0", 2, PERIOD, -1, 8'h0, 8'h0, h);
    chk("ch2_dutyC0_highs", h, 192);

    // ctrl modes; ctrl takes effect one cycle after the write, no wrap needed
    wr(8'h41, 8'h01);
    chk("ch1_ctrl_before", int'(out[1]), 0);
    @(negedge clk);
    chk("ch1_ctrl_after", int'(out[1]), 1);
    measure("ch1_force1", 1, PERIOD, -1, 8'h0, 8'h0, h);
    chk("ch1_force1_highs", h, PERIOD);
    wr(8'h41, 8'h02);
    measure("ch1_pwm_no_out", 1, PERIOD, -1, 8'h0, 8'h0, h);
    chk("ch1_pwm_no_out_highs", h, 0);
    // unmapped addresses must not change anything
    wr(8'h50, 8'h03);
    wr(8'h10, 8'hFF);
    wr(8'h81, 8'h05);
    measure("ch0_after_bad_wr", 0, PERIOD, -1, 8'h0, 8'h0, h);
    chk("ch0_after_bad_wr_highs", h, 128);
    chk("ch1_after_bad_wr", int'(out[1]), 0);

    // prescaler 3: 4 cycles per count, 1020-cycle period
    wr(8'h80, 8'h03);
    measure("presc3", 0, 4 * PERIOD, -1, 8'h0, 8'h0, h);
    chk("presc3_highs", h, 4 * 128);
    repeat (7) @(negedge clk);
    wr(8'h80, 8'h03);
    repeat (9) @(negedge clk);
    wr(8'h80, 8'h00);

    // reset mid-period with a pending duty on ch5
    wr(8'h05, 8'hA0);
    wr(8'h45, 8'h03);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out", int'(out), 0);
    chk("midreset_pulse", int'(period_pulse), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nz = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (out != '0) nz++;
    end
    chk("post_reset_out_zero_cycles", nz, 0);
    measure("post_reset_period", 5, PERIOD, -1, 8'h0, 8'h0, h);
    chk("post_reset_ch5_highs", h, 0);

    // mixed register writes checked by the every-cycle model compare
    for (int n = 0; n < 40; n++) begin
      int sel;
      logic [7:0] a;
      logic [7:0] d;
      sel = $urandom_range(0, 9);
      d   = 8'($urandom_range(0, 255));
      if (sel < 4)       a = 8'($urandom_range(0, NCH - 1));
      else if (sel < 8)  a = 8'(64 + $urandom_range(0, NCH - 1));
      else if (sel == 8) begin a = 8'h80; d = 8'($urandom_range(0, 2)); end
      else               a = 8'($urandom_range(8'h50, 8'h7F));
      wr(a, d);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    repeat (600) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, number of PWM channels (1..64).
REQ-002 SHALL have parameter CNT_W, default 8, counter and duty width in bits (4..16).
REQ-003 SHALL have parameter PRESC_W, default 8, prescaler register width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port wr_en  input  1  register write strobe, one write per cycle.
REQ-007 SHALL have port wr_addr  input  8  register address.
REQ-008 SHALL have port wr_data  input  CNT_W  write data; upper bits ignored for narrower registers.
REQ-009 SHALL have port out  output  NUM_CH  registered PWM outputs, bit i = channel i.
REQ-010 SHALL have port period_pulse  output  1  one-cycle high at each period wrap.

Function
REQ-011 SHALL decode the address map: 0x00+i duty shadow of channel i; 0x40+i ctrl of channel i (bit0 en_out, bit1 en_pwm); 0x80 prescaler; all others ignored, including i >= NUM_CH.
REQ-012 SHALL assert tick when presc_cnt equals the prescaler register, then clear presc_cnt; otherwise presc_cnt increments; prescaler 0 gives a tick every cycle.
REQ-013 SHALL clear presc_cnt in the cycle after any prescaler write.
REQ-014 SHALL increment the period counter on tick, over 0..2^CNT_W-2 (period = 2^CNT_W-1 ticks), wrapping to 0.
REQ-015 SHALL assert period_pulse, registered, in the cycle after a tick with the counter at 2^CNT_W-2.
REQ-016 SHALL, per channel, load active duty from the shadow duty on the wrap tick.
REQ-017 SHALL load wr_data, not the stale shadow, when a duty write to that channel coincides with the wrap tick.
REQ-018 SHALL compute the next value of out[i] as: 0 when en_out=0; 1 when en_out=1 and en_pwm=0; otherwise (counter < active duty) OR (active duty = all ones).
REQ-019 SHALL register out, one cycle latency from counter and ctrl.
REQ-020 SHALL apply ctrl writes to the output computation in the cycle after the write, without waiting for a wrap.
REQ-021 SHALL hold out[i] constantly 0 for duty 0, and constantly 1 for duty 2^CNT_W-1.

Reset
REQ-022 SHALL clear, while rst_n=0, all of: out, period_pulse, presc_cnt, counter, shadow duty, active duty, ctrl, and the prescaler register.
REQ-023 SHALL, on rst_n deassertion, start counting from 0 on the first clock; a reset mid-period SHALL discard pending shadow values.

Configuration
REQ-024 SHALL, with macro PWM_BANK_SYNC_UPDATE_EN defined, implement the shadow/active double buffer of REQ-016/017.
REQ-025 SHALL, without PWM_BANK_SYNC_UPDATE_EN, omit the active registers: duty writes take effect in the cycle after the write, and the comparison uses the shadow directly.

Structure
REQ-026 SHALL take address constants (0x00, 0x40, 0x80), the ctrl bit positions, and the register-type enum from shared package pwm_bank_pkg.
REQ-027 SHALL instantiate NUM_CH copies of sub-module pwm_bank_channel, each holding shadow/active duty, ctrl and the compare/output register; the prescaler and period counter stay in pwm_bank.

Verification
REQ-028 SHALL cover: prescaler 0, ch0 ctrl=0x3, duty=0x80 -> out[0] high 128 of every 255 cycles, period_pulse every 255 cycles.
REQ-029 SHALL cover: ch3 duty 0x00 then 0xFF, ctrl=0x3 -> out[3] constantly 0, then constantly 1 from the wrap after the write.
REQ-030 SHALL cover: with SYNC_UPDATE_EN, duty 0x40 to 0xC0 written mid-period -> current period keeps 64 high cycles, next period has 192; without the macro, the change appears in the next cycle.
REQ-031 SHALL cover: prescaler=3 -> counter advances every 4 cycles, period_pulse every 1020 cycles; a prescaler write restarts the count.
REQ-032 SHALL cover: ctrl=0x1 -> out constant 1; ctrl=0x2 -> out 0; write to 0x50 with NUM_CH=16 -> no state change.
REQ-033 SHALL cover: rst_n pulsed low mid-period with duty pending -> all outputs 0 immediately, out stays 0 until reprogrammed.
